pattern_blinker: RTL and testbench

Parametrised multi-channel LED blink sequencer for lock status feedback (error, programmed, waiting, wrong-digit).
The controller selects one of four stored patterns and a set of LEDs, then pulses start.
The block plays the pattern (finite count or continuous), reports busy/done, and accepts abort.
Replaces the fixed two-pattern single-LED blinker.

---
 rtl/blink_pkg.sv | 36 +++
 rtl/blink_phase_timer.sv | 32 +++
 rtl/pattern_blinker.sv | 161 ++++++++++++++++
 tb/tb_pattern_blinker.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared encodings and default timing for the lock-status LED blink sequencer.
package blink_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_ERROR = 2'd0;
  localparam logic [MODE_W-1:0] MODE_PROG  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_WAIT  = 2'd2;
  localparam logic [MODE_W-1:0] MODE_WRONG = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_e;

  // Default pattern periods in 12 MHz cycles
  localparam int unsigned DEF_ON0  = 6000000;
  localparam int unsigned DEF_OFF0 = 12000000;
  localparam int unsigned DEF_CNT0 = 3;
  localparam int unsigned DEF_ON1  = 2400000;
  localparam int unsigned DEF_OFF1 = 2400000;
  localparam int unsigned DEF_CNT1 = 5;
  localparam int unsigned DEF_ON2  = 6000000;
  localparam int unsigned DEF_OFF2 = 6000000;
  localparam int unsigned DEF_CNT2 = 0;
  localparam int unsigned DEF_ON3  = 1200000;
  localparam int unsigned DEF_OFF3 = 1200000;
  localparam int unsigned DEF_CNT3 = 2;

  // True when val is representable in w bits
  function automatic logic fits(input logic [63:0] val, input int unsigned w);
    return (val >> w) == 64'd0;
  endfunction

endpackage

// File: rtl/blink_phase_timer.sv
// Loadable phase down-counter; expire is high for the one cycle the count sits at zero.
module blink_phase_timer #(
  parameter int unsigned TIMER_W = 24
) (
  input  logic               hwclk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  output logic [TIMER_W-1:0] count,
  output logic               expire
);

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      expire <= 1'b0;
    end else if (clr) begin
      count  <= '0;
      expire <= 1'b0;
    end else if (load) begin
      count  <= value;
      expire <= (value == '0);
    end else if (count != '0) begin
      count  <= count - TIMER_W'(1);
      expire <= (count == TIMER_W'(1));
    end else begin
      expire <= 1'b0;
    end
  end

endmodule

// File: rtl/pattern_blinker.sv
// Multi-channel LED blink sequencer: plays one of four stored on/off/count patterns
// on a latched LED mask, with busy/done status and abort.
module pattern_blinker
  import blink_pkg::*;
#(
  parameter int unsigned N_LED          = 4,
  parameter int unsigned TIMER_W        = 24,
  parameter int unsigned CNT_W          = 4,
  parameter int unsigned LED_ACTIVE_LOW = 0,
  parameter int unsigned ON0            = DEF_ON0,
  parameter int unsigned OFF0           = DEF_OFF0,
  parameter int unsigned CNT0           = DEF_CNT0,
  parameter int unsigned ON1            = DEF_ON1,
  parameter int unsigned OFF1           = DEF_OFF1,
  parameter int unsigned CNT1           = DEF_CNT1,
  parameter int unsigned ON2            = DEF_ON2,
  parameter int unsigned OFF2           = DEF_OFF2,
  parameter int unsigned CNT2           = DEF_CNT2,
  parameter int unsigned ON3            = DEF_ON3,
  parameter int unsigned OFF3           = DEF_OFF3,
  parameter int unsigned CNT3           = DEF_CNT3
) (
  input  logic              hwclk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MODE_W-1:0] mode,
  input  logic [N_LED-1:0]  led_mask,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [N_LED-1:0]  led
);

  localparam logic INV = (LED_ACTIVE_LOW != 0);

  if (!(fits(64'(ON0), TIMER_W) && fits(64'(OFF0), TIMER_W) && fits(64'(CNT0), CNT_W) &&
        fits(64'(ON1), TIMER_W) && fits(64'(OFF1), TIMER_W) && fits(64'(CNT1), CNT_W) &&
        fits(64'(ON2), TIMER_W) && fits(64'(OFF2), TIMER_W) && fits(64'(CNT2), CNT_W) &&
        fits(64'(ON3), TIMER_W) && fits(64'(OFF3), TIMER_W) && fits(64'(CNT3), CNT_W)))
  begin : g_table_check
    $error("pattern_blinker: pattern table value wider than TIMER_W/CNT_W");
  end

  // Timer reload values are period-1; a period of 0 is treated as 1
  localparam logic [TIMER_W-1:0] ON_M1 [4] = '{
    TIMER_W'((ON0 == 0) ? 32'd0 : ON0 - 32'd1), TIMER_W'((ON1 == 0) ? 32'd0 : ON1 - 32'd1),
    TIMER_W'((ON2 == 0) ? 32'd0 : ON2 - 32'd1), TIMER_W'((ON3 == 0) ? 32'd0 : ON3 - 32'd1)};
  localparam logic [TIMER_W-1:0] OFF_M1 [4] = '{
    TIMER_W'((OFF0 == 0) ? 32'd0 : OFF0 - 32'd1), TIMER_W'((OFF1 == 0) ? 32'd0 : OFF1 - 32'd1),
    TIMER_W'((OFF2 == 0) ? 32'd0 : OFF2 - 32'd1), TIMER_W'((OFF3 == 0) ? 32'd0 : OFF3 - 32'd1)};
  localparam logic [CNT_W-1:0] CNT_T [4] = '{
    CNT_W'(CNT0), CNT_W'(CNT1), CNT_W'(CNT2), CNT_W'(CNT3)};

  state_e              state_q, state_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [N_LED-1:0]    mask_q, mask_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                busy_d, done_d;
  logic [N_LED-1:0]    led_d;
  logic                last_blink;

  logic                t_clr, t_load, t_expire;
  logic [TIMER_W-1:0]  t_value, t_count;

  logic [TIMER_W-1:0]  on_sel, off_sel;
  logic [CNT_W-1:0]    cnt_sel;

  assign on_sel  = ON_M1[mode_q];
  assign off_sel = OFF_M1[mode_q];
  assign cnt_sel = CNT_T[mode_q];

  blink_phase_timer #(.TIMER_W(TIMER_W)) u_timer (
    .hwclk  (hwclk),
    .rst_n  (rst_n),
    .clr    (t_clr),
    .load   (t_load),
    .value  (t_value),
    .count  (t_count),
    .expire (t_expire)
  );

  // Next state; done is raised one cycle early so it coincides with the final OFF cycle
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    mask_d     = mask_q;
    count_d    = count_q;
    t_clr      = 1'b0;
    t_load     = 1'b0;
    t_value    = on_sel;
    done_d     = 1'b0;
    last_blink = (cnt_sel != '0) && (CNT_W'(count_q + 1'b1) == cnt_sel);

    if (abort) begin
      state_d = IDLE;
      count_d = '0;
      t_clr   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_d  = mode;
            mask_d  = led_mask;
            count_d = '0;
            t_load  = 1'b1;
            t_value = ON_M1[mode];
            state_d = ON;
          end
        end
        ON: begin
          if (t_expire) begin
            t_load  = 1'b1;
            t_value = off_sel;
            state_d = OFF;
            done_d  = last_blink && (off_sel == '0);
          end
        end
        OFF: begin
          if (t_expire) begin
            if (cnt_sel != '0) count_d = CNT_W'(count_q + 1'b1);
            if (last_blink) begin
              state_d = IDLE;
            end else begin
              t_load  = 1'b1;
              t_value = on_sel;
              state_d = ON;
            end
          end else begin
            done_d = last_blink && (t_count == TIMER_W'(1));
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
    led_d  = (state_d == ON) ? mask_d : '0;
    if (INV) led_d = ~led_d;
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= '0;
      mask_q  <= '0;
      count_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      led     <= {N_LED{INV}};
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      busy    <= busy_d;
      done    <= done_d;
      led     <= led_d;
    end
  end

endmodule

// File: tb/tb_pattern_blinker.sv
// Directed bench for pattern_blinker: an active-high instance with short periods
// and an active-low instance for polarity.
module tb_pattern_blinker;

  logic hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  logic       rst_n;
  logic       start_a, abort_a, busy_a, done_a;
  logic [1:0] mode_a;
  logic [3:0] mask_a, led_a;
  logic       start_b, abort_b, busy_b, done_b;
  logic [1:0] mode_b;
  logic [3:0] mask_b, led_b;

  int checks = 0;
  int errors = 0;

  pattern_blinker #(
    .N_LED(4), .LED_ACTIVE_LOW(0),
    .ON0(0), .OFF0(2), .CNT0(1),
    .ON1(3), .OFF1(2), .CNT1(2),
    .ON2(2), .OFF2(2), .CNT2(0),
    .ON3(1), .OFF3(1), .CNT3(1)
  ) dut_a (
    .hwclk(hwclk), .rst_n(rst_n), .start(start_a), .mode(mode_a), .led_mask(mask_a),
    .abort(abort_a), .busy(busy_a), .done(done_a), .led(led_a)
  );

  pattern_blinker #(
    .N_LED(4), .LED_ACTIVE_LOW(1),
    .ON0(1), .OFF0(1), .CNT0(1),
    .ON1(1), .OFF1(1), .CNT1(1),
    .ON2(1), .OFF2(1), .CNT2(0),
    .ON3(2), .OFF3(1), .CNT3(2)
  ) dut_b (
    .hwclk(hwclk), .rst_n(rst_n), .start(start_b), .mode(mode_b), .led_mask(mask_b),
    .abort(abort_b), .busy(busy_b), .done(done_b), .led(led_b)
  );

  task automatic step();
    @(posedge hwclk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (led_a !== 4'b0000) begin errors++; $display("FAIL reset_led_a got %b expected 0000", led_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a got %b expected 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done_a got %b expected 0", done_a); end
    checks++; if (led_b !== 4'b1111) begin errors++; $display("FAIL reset_led_b got %b expected 1111", led_b); end
    rst_n = 1'b1;
    step();
    checks++; if (busy_a !== 1'b0 || led_b !== 4'b1111) begin
      errors++; $display("FAIL post_reset_idle busy_a=%b led_b=%b expected 0/1111", busy_a, led_b);
    end
  endtask

  // Mode 1: on 3, off 2, two blinks; inputs are scrambled mid-sequence
  task automatic test_programmed();
    logic [3:0] exp_led;
    logic       exp_busy, exp_done;
    start_a = 1'b1; mode_a = 2'd1; mask_a = 4'b0101;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_led  = ((k >= 1 && k <= 3) || (k >= 6 && k <= 8)) ? 4'b0101 : 4'b0000;
      exp_busy = (k <= 10);
      exp_done = (k == 10);
      checks++; if (led_a !== exp_led) begin errors++; $display("FAIL prog_led cycle %0d got %b expected %b", k, led_a, exp_led); end
      checks++; if (busy_a !== exp_busy) begin errors++; $display("FAIL prog_busy cycle %0d got %b expected %b", k, busy_a, exp_busy); end
      checks++; if (done_a !== exp_done) begin errors++; $display("FAIL prog_done cycle %0d got %b expected %b", k, done_a, exp_done); end
      start_a = 1'b0;
      if (k == 2) begin mode_a = 2'd2; mask_a = 4'b1010; end
    end
  endtask

  // Starts while busy and in the done cycle are ignored; the one after done is taken
  task automatic test_back_to_back();
    logic [3:0] exp_led;
    logic       exp_busy, exp_done;
    start_a = 1'b1; mode_a = 2'd1; mask_a = 4'b0011;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k <= 11) begin
        exp_led  = ((k >= 1 && k <= 3) || (k >= 6 && k <= 8)) ? 4'b0011 : 4'b0000;
        exp_busy = (k <= 10);
        exp_done = (k == 10);
      end else begin
        exp_led  = 4'b0011;
        exp_busy = 1'b1;
        exp_done = 1'b0;
      end
      checks++; if (led_a !== exp_led) begin errors++; $display("FAIL b2b_led cycle %0d got %b expected %b", k, led_a, exp_led); end
      checks++; if (busy_a !== exp_busy) begin errors++; $display("FAIL b2b_busy cycle %0d got %b expected %b", k, busy_a, exp_busy); end
      checks++; if (done_a !== exp_done) begin errors++; $display("FAIL b2b_done cycle %0d got %b expected %b", k, done_a, exp_done); end
      start_a = (k == 3 || k == 10 || k == 11);
    end
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    checks++; if (busy_a !== 1'b0 || led_a !== 4'b0000 || done_a !== 1'b0) begin
      errors++; $display("FAIL b2b_abort busy=%b led=%b done=%b expected 0/0000/0", busy_a, led_a, done_a);
    end
  endtask

  // Mode 2 runs continuously at 2/2 until aborted in cycle 20
  task automatic test_continuous();
    logic [3:0] exp_led;
    start_a = 1'b1; mode_a = 2'd2; mask_a = 4'b1111;
    for (int k = 1; k <= 20; k++) begin
      step();
      start_a = 1'b0;
      exp_led = (((k - 1) / 2) % 2 == 0) ? 4'b1111 : 4'b0000;
      checks++; if (led_a !== exp_led) begin errors++; $display("FAIL cont_led cycle %0d got %b expected %b", k, led_a, exp_led); end
      checks++; if (busy_a !== 1'b1 || done_a !== 1'b0) begin
        errors++; $display("FAIL cont_status cycle %0d busy=%b done=%b expected 1/0", k, busy_a, done_a);
      end
    end
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    checks++; if (led_a !== 4'b0000 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++; $display("FAIL cont_abort led=%b busy=%b done=%b expected 0000/0/0", led_a, busy_a, done_a);
    end
    step();
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++; $display("FAIL cont_after_abort busy=%b done=%b expected 0/0", busy_a, done_a);
    end
  endtask

  // Reset asserted between edges clears outputs at once; a fresh start then runs normally
  task automatic test_async_reset();
    start_a = 1'b1; mode_a = 2'd1; mask_a = 4'b1111;
    step();
    start_a = 1'b0;
    step();
    checks++; if (led_a !== 4'b1111) begin errors++; $display("FAIL arst_pre_led got %b expected 1111", led_a); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (led_a !== 4'b0000 || busy_a !== 1'b0) begin
      errors++; $display("FAIL arst_immediate led=%b busy=%b expected 0000/0", led_a, busy_a);
    end
    @(posedge hwclk);
    #3 rst_n = 1'b1;
    step();
    checks++; if (busy_a !== 1'b0 || led_a !== 4'b0000 || done_a !== 1'b0) begin
      errors++; $display("FAIL arst_idle busy=%b led=%b done=%b expected 0/0000/0", busy_a, led_a, done_a);
    end
    start_a = 1'b1; mode_a = 2'd1; mask_a = 4'b0110;
    step();
    start_a = 1'b0;
    checks++; if (led_a !== 4'b0110 || busy_a !== 1'b1) begin
      errors++; $display("FAIL arst_restart_c1 led=%b busy=%b expected 0110/1", led_a, busy_a);
    end
    step();
    step();
    checks++; if (led_a !== 4'b0110) begin errors++; $display("FAIL arst_restart_c3 got %b expected 0110", led_a); end
    step();
    checks++; if (led_a !== 4'b0000) begin errors++; $display("FAIL arst_restart_c4 got %b expected 0000", led_a); end
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL arst_cleanup busy got %b expected 0", busy_a); end
  endtask

  // Active-low instance, mode 3: on 2, off 1, two blinks on channel 0
  task automatic test_active_low();
    logic [3:0] exp_led;
    logic       exp_busy, exp_done;
    start_b = 1'b1; mode_b = 2'd3; mask_b = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      step();
      start_b  = 1'b0;
      exp_led  = (k == 1 || k == 2 || k == 4 || k == 5) ? 4'b1110 : 4'b1111;
      exp_busy = (k <= 6);
      exp_done = (k == 6);
      checks++; if (led_b !== exp_led) begin errors++; $display("FAIL alow_led cycle %0d got %b expected %b", k, led_b, exp_led); end
      checks++; if (busy_b !== exp_busy) begin errors++; $display("FAIL alow_busy cycle %0d got %b expected %b", k, busy_b, exp_busy); end
      checks++; if (done_b !== exp_done) begin errors++; $display("FAIL alow_done cycle %0d got %b expected %b", k, done_b, exp_done); end
    end
  endtask

  task automatic test_abort_start();
    start_a = 1'b1; abort_a = 1'b1; mode_a = 2'd1; mask_a = 4'b1111;
    step();
    start_a = 1'b0; abort_a = 1'b0;
    checks++; if (busy_a !== 1'b0 || led_a !== 4'b0000) begin
      errors++; $display("FAIL abort_start busy=%b led=%b expected 0/0000", busy_a, led_a);
    end
    step();
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++; $display("FAIL abort_start_hold busy=%b done=%b expected 0/0", busy_a, done_a);
    end
  endtask

  // Mode 0 with ON=0: one lit cycle, two dark cycles, single blink
  task automatic test_on_zero();
    logic [3:0] exp_led;
    logic       exp_busy, exp_done;
    start_a = 1'b1; mode_a = 2'd0; mask_a = 4'b1111;
    for (int k = 1; k <= 4; k++) begin
      step();
      start_a  = 1'b0;
      exp_led  = (k == 1) ? 4'b1111 : 4'b0000;
      exp_busy = (k <= 3);
      exp_done = (k == 3);
      checks++; if (led_a !== exp_led) begin errors++; $display("FAIL on0_led cycle %0d got %b expected %b", k, led_a, exp_led); end
      checks++; if (busy_a !== exp_busy) begin errors++; $display("FAIL on0_busy cycle %0d got %b expected %b", k, busy_a, exp_busy); end
      checks++; if (done_a !== exp_done) begin errors++; $display("FAIL on0_done cycle %0d got %b expected %b", k, done_a, exp_done); end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; mode_a = 2'd0; mask_a = 4'b0000;
    start_b = 1'b0; abort_b = 1'b0; mode_b = 2'd0; mask_b = 4'b0000;
    test_reset();
    test_programmed();
    test_back_to_back();
    test_continuous();
    test_async_reset();
    test_active_low();
    test_abort_start();
    test_on_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
